// File: rtl/pwm_gate_sequencer_pkg.sv
// Shared definitions for the SPWM gate sequencer: FSM state codes and timing defaults.

package pwm_gate_sequencer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BOOT    = 3'd1;
  localparam logic [2:0] ST_RAMP_UP = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_RAMP_DN = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  localparam int unsigned DEAD_CYCLES_DEF = 50;
  localparam int unsigned BOOT_CYCLES_DEF = 5000;

  // Legs switch with the comparators only while the inverter is modulating.
  function automatic logic leg_active(input logic [2:0] st);
    return (st == ST_RAMP_UP) || (st == ST_RUN) || (st == ST_RAMP_DN);
  endfunction

endpackage

// File: rtl/pwm_gate_sequencer_dead_time_leg.sv
// One complementary inverter leg: follows raw through a dead-time interval, never both sides on.

module dead_time_leg #(
  parameter int unsigned DT_W        = 8,
  parameter int unsigned DEAD_CYCLES = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_force_low,
  input  logic i_raw,
  output logic o_hi,
  output logic o_lo
);

  localparam logic [DT_W-1:0] DeadLoad = DT_W'(DEAD_CYCLES);

  logic [DT_W-1:0] r_cnt;
  logic            r_raw;
  logic            r_en;
  logic            r_hi;
  logic            r_lo;
  logic            w_restart;

  // A fresh enable counts as an edge so a leg never turns on without dead time.
  assign w_restart = ~r_en | (i_raw ^ r_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_raw <= 1'b0;
      r_en  <= 1'b0;
      r_hi  <= 1'b0;
      r_lo  <= 1'b0;
    end else begin
      r_raw <= i_raw;
      r_en  <= i_en;
      if (!i_en) begin
        r_cnt <= '0;
        r_hi  <= 1'b0;
        r_lo  <= i_force_low;
      end else if (w_restart) begin
        r_cnt <= DeadLoad;
        r_hi  <= 1'b0;
        r_lo  <= 1'b0;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        r_hi  <= 1'b0;
        r_lo  <= 1'b0;
      end else begin
        r_hi  <= i_raw;
        r_lo  <= ~i_raw;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/pwm_gate_sequencer.sv
// 3-phase SPWM gate sequencer: bootstrap, index ramps, run, stop and fault handling.

module pwm_gate_sequencer
  import pwm_gate_sequencer_pkg::*;
#(
  parameter int unsigned MOD_W       = 8,
  parameter int unsigned MOD_MAX     = 255,
  parameter int unsigned RAMP_STEP   = 1,
  parameter int unsigned DT_W        = 8,
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int unsigned BOOT_W      = 16,
  parameter int unsigned BOOT_CYCLES = BOOT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_fault_in,
  input  logic             i_clear_fault,
  input  logic             i_carrier_peak,
  input  logic             i_raw_a,
  input  logic             i_raw_b,
  input  logic             i_raw_c,
  output logic [MOD_W-1:0] o_mod_index,
  output logic             o_va,
  output logic             o_van,
  output logic             o_vb,
  output logic             o_vbn,
  output logic             o_vc,
  output logic             o_vcn,
  output logic [2:0]       o_state,
  output logic             o_fault_latched
);

  localparam logic [MOD_W:0]    ModMaxW  = (MOD_W+1)'(MOD_MAX);
  localparam logic [MOD_W:0]    StepW    = (MOD_W+1)'(RAMP_STEP);
  localparam logic [BOOT_W-1:0] BootLast = BOOT_W'(BOOT_CYCLES - 1);

  logic [2:0]       r_state, w_state_nxt;
  logic [MOD_W-1:0] r_mod, w_mod_nxt;
  logic [BOOT_W-1:0] r_boot, w_boot_nxt;
  logic [MOD_W:0]   w_sum, w_up_sat;
  logic [MOD_W-1:0] w_mod_up, w_mod_dn, w_mod_max;
  logic             w_leg_en, w_boot_low;

  assign w_sum     = {1'b0, r_mod} + StepW;
  assign w_up_sat  = (w_sum > ModMaxW) ? ModMaxW : w_sum;
  assign w_mod_max = ModMaxW[MOD_W-1:0];
  assign w_mod_up  = i_carrier_peak ? w_up_sat[MOD_W-1:0] : r_mod;
  assign w_mod_dn  = !i_carrier_peak ? r_mod :
                     ({1'b0, r_mod} >= StepW) ? (r_mod - StepW[MOD_W-1:0]) : '0;

  // Enable/fault driven transitions suppress the index update on a coincident peak.
  always_comb begin
    w_state_nxt = r_state;
    w_mod_nxt   = r_mod;
    w_boot_nxt  = r_boot;
    if (i_fault_in) begin
      w_state_nxt = ST_FAULT;
      w_mod_nxt   = '0;
      w_boot_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            w_state_nxt = ST_BOOT;
            w_boot_nxt  = '0;
          end
        end
        ST_BOOT: begin
          if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_boot_nxt  = '0;
          end else if (r_boot == BootLast) begin
            w_state_nxt = ST_RAMP_UP;
            w_boot_nxt  = '0;
          end else begin
            w_boot_nxt  = r_boot + 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (!i_enable) begin
            w_state_nxt = ST_RAMP_DN;
          end else begin
            w_mod_nxt = w_mod_up;
            if (w_mod_up == w_mod_max) w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_mod_nxt = w_mod_max;
          if (!i_enable) w_state_nxt = ST_RAMP_DN;
        end
        ST_RAMP_DN: begin
          if (i_enable) begin
            w_state_nxt = ST_RAMP_UP;
          end else begin
            w_mod_nxt = w_mod_dn;
            if (w_mod_dn == '0) w_state_nxt = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (i_clear_fault) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_mod_nxt   = '0;
          w_boot_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mod   <= '0;
      r_boot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mod   <= w_mod_nxt;
      r_boot  <= w_boot_nxt;
    end
  end

  // Fault gates the legs combinationally so the gates drop on the entry edge itself.
  assign w_leg_en   = ~i_fault_in & leg_active(r_state);
  assign w_boot_low = ~i_fault_in & (r_state == ST_BOOT);

  dead_time_leg #(.DT_W(DT_W), .DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_leg_en),
    .i_force_low(w_boot_low),
    .i_raw      (i_raw_a),
    .o_hi       (o_va),
    .o_lo       (o_van)
  );

  dead_time_leg #(.DT_W(DT_W), .DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_leg_en),
    .i_force_low(w_boot_low),
    .i_raw      (i_raw_b),
    .o_hi       (o_vb),
    .o_lo       (o_vbn)
  );

  dead_time_leg #(.DT_W(DT_W), .DEAD_CYCLES(DEAD_CYCLES)) u_leg_c (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_leg_en),
    .i_force_low(w_boot_low),
    .i_raw      (i_raw_c),
    .o_hi       (o_vc),
    .o_lo       (o_vcn)
  );

  assign o_mod_index     = r_mod;
  assign o_state         = r_state;
  assign o_fault_latched = (r_state == ST_FAULT);

endmodule

// File: tb/tb_pwm_gate_sequencer.sv
// Bench for pwm_gate_sequencer: timestamp-based behavioural model plus directed literal checks.

module tb_pwm_gate_sequencer;
  import pwm_gate_sequencer_pkg::*;

  localparam int DEAD   = 50;
  localparam int BOOT   = 5000;
  localparam int MODMAX = 255;
  localparam int STEP   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, fault_in = 1'b0, clear_fault = 1'b0, carrier_peak = 1'b0;
  logic       raw_a = 1'b0, raw_b = 1'b0, raw_c = 1'b0;
  logic [7:0] mod_index;
  logic       va, van, vb, vbn, vc, vcn;
  logic [2:0] state;
  logic       fault_latched;

  pwm_gate_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_fault_in     (fault_in),
    .i_clear_fault  (clear_fault),
    .i_carrier_peak (carrier_peak),
    .i_raw_a        (raw_a),
    .i_raw_b        (raw_b),
    .i_raw_c        (raw_c),
    .o_mod_index    (mod_index),
    .o_va           (va),
    .o_van          (van),
    .o_vb           (vb),
    .o_vbn          (vbn),
    .o_vc           (vc),
    .o_vcn          (vcn),
    .o_state        (state),
    .o_fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_BOOT, M_UP, M_RUN, M_DN, M_FAULT} mst_t;

  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 0;
  bit   peak_en = 0, raw_rand = 0, rand_ctl = 0;
  int   cyc = 0;

  // Model: state by name, index as an integer, each leg as "cycle of last restart".
  mst_t       m_st;
  int         m_n, m_mod, m_boot;
  int         m_last[3];
  logic [2:0] m_prev_raw, m_hi, m_lo;
  bit         m_prev_en;

  function automatic logic [2:0] code_of(input mst_t s);
    case (s)
      M_BOOT:  return ST_BOOT;
      M_UP:    return ST_RAMP_UP;
      M_RUN:   return ST_RUN;
      M_DN:    return ST_RAMP_DN;
      M_FAULT: return ST_FAULT;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_n = 0; m_mod = 0; m_boot = 0;
    m_prev_raw = '0; m_prev_en = 0; m_hi = '0; m_lo = '0;
    for (int p = 0; p < 3; p++) m_last[p] = 0;
  endtask

  task automatic model_step();
    logic [2:0] rw;
    bit leg, bl;
    rw  = {raw_c, raw_b, raw_a};
    leg = !fault_in && (m_st == M_UP || m_st == M_RUN || m_st == M_DN);
    bl  = !fault_in && (m_st == M_BOOT);
    m_n++;
    for (int p = 0; p < 3; p++) begin
      if (leg) begin
        if (!m_prev_en || rw[p] != m_prev_raw[p]) m_last[p] = m_n;
        if (m_n - m_last[p] <= DEAD) begin m_hi[p] = 0; m_lo[p] = 0; end
        else begin m_hi[p] = rw[p]; m_lo[p] = !rw[p]; end
      end else begin
        m_hi[p] = 0; m_lo[p] = bl;
      end
    end
    m_prev_en = leg; m_prev_raw = rw;
    if (fault_in) begin
      m_st = M_FAULT; m_mod = 0;
    end else begin
      case (m_st)
        M_IDLE: if (enable) begin m_st = M_BOOT; m_boot = 0; end
        M_BOOT: begin
          if (!enable) m_st = M_IDLE;
          else begin
            m_boot++;
            if (m_boot == BOOT) m_st = M_UP;
          end
        end
        M_UP: begin
          if (!enable) m_st = M_DN;
          else begin
            if (carrier_peak) m_mod = (m_mod + STEP > MODMAX) ? MODMAX : m_mod + STEP;
            if (m_mod == MODMAX) m_st = M_RUN;
          end
        end
        M_RUN: if (!enable) m_st = M_DN;
        M_DN: begin
          if (enable) m_st = M_UP;
          else begin
            if (carrier_peak) m_mod = (m_mod < STEP) ? 0 : m_mod - STEP;
            if (m_mod == 0) m_st = M_IDLE;
          end
        end
        default: if (clear_fault) m_st = M_IDLE;
      endcase
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0d want %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [17:0] exp_v, got_v;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    if (chk_on) begin
      exp_v = {8'(m_mod), code_of(m_st), m_st == M_FAULT,
               m_hi[0], m_lo[0], m_hi[1], m_lo[1], m_hi[2], m_lo[2]};
      got_v = {mod_index, state, fault_latched, va, van, vb, vbn, vc, vcn};
      chk("model", int'(got_v), int'(exp_v));
      chk("overlap", int'((va & van) | (vb & vbn) | (vc & vcn)), 0);
    end
    cyc++;
    carrier_peak = peak_en && (cyc % 4 == 0);
    if (raw_rand) begin
      if ($urandom_range(0, 47) == 0) raw_a = ~raw_a;
      if ($urandom_range(0, 47) == 0) raw_b = ~raw_b;
      if ($urandom_range(0, 47) == 0) raw_c = ~raw_c;
    end
    if (rand_ctl) begin
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
      fault_in    = ($urandom_range(0, 3999) == 0) ? 1'b1 :
                    (fault_in && $urandom_range(0, 15) != 0);
      clear_fault = ($urandom_range(0, 63) == 0);
    end
  endtask

  initial begin
    int lows, ups, dns, off, prev, boots;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gates", int'({va, van, vb, vbn, vc, vcn}), 0);
    chk("rst_mod", int'(mod_index), 0);
    chk("rst_state", int'(state), int'(ST_IDLE));
    chk("rst_fault", int'(fault_latched), 0);
    rst_n = 1'b1;
    chk_on = 1;

    // Start-up: bootstrap then ramp to full index.
    enable = 1; peak_en = 1; raw_rand = 1;
    tick();
    chk("boot_entry", int'(state), int'(ST_BOOT));
    lows = 0; ups = 0; prev = 0;
    for (int i = 0; i < 7000; i++) begin
      tick();
      if ({van, vbn, vcn} == 3'b111 && {va, vb, vc} == 3'b000) lows++;
      if (int'(mod_index) == prev + 1) ups++;
      prev = int'(mod_index);
      if (state == ST_RUN) break;
    end
    chk("boot_len", lows, 5000);
    chk("ramp_steps", ups, 255);
    chk("run_state", int'(state), int'(ST_RUN));
    chk("run_mod", int'(mod_index), 255);

    // Dead time: single edge, then an edge 20 cycles into the interval.
    raw_rand = 0; raw_a = 0;
    repeat (80) tick();
    chk("dt_settle", int'({va, van}), 1);
    raw_a = 1; off = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (va | van) break; off++; end
    chk("dt_single", off, 51);
    chk("dt_side_hi", int'({va, van}), 2);
    repeat (80) tick();
    raw_a = 0; off = 0;
    repeat (20) begin tick(); if (!(va | van)) off++; end
    raw_a = 1;
    for (int i = 0; i < 200; i++) begin tick(); if (va | van) break; off++; end
    chk("dt_restart", off, 71);
    chk("dt_restart_side", int'({va, van}), 2);

    // Stop to index 100, then restart without bootstrap.
    raw_rand = 1; enable = 0; dns = 0; prev = int'(mod_index);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (int'(mod_index) == prev - 1) dns++;
      prev = int'(mod_index);
      if (mod_index == 8'd100) break;
    end
    chk("dn_steps", dns, 155);
    enable = 1;
    tick();
    chk("resume_state", int'(state), int'(ST_RAMP_UP));
    chk("resume_mod", int'(mod_index), 100);
    boots = 0;
    repeat (40) begin tick(); if (state == ST_BOOT) boots++; end
    chk("no_boot", boots, 0);
    chk("resume_climb", int'(mod_index > 8'd100), 1);

    // Fault during ramp-up; clear only takes once fault_in is low.
    fault_in = 1;
    tick();
    chk("flt_gates", int'({va, van, vb, vbn, vc, vcn}), 0);
    chk("flt_mod", int'(mod_index), 0);
    chk("flt_latched", int'(fault_latched), 1);
    clear_fault = 1;
    tick();
    chk("flt_clear_blocked", int'(state), int'(ST_FAULT));
    clear_fault = 0; fault_in = 0; enable = 0;
    tick();
    chk("flt_hold", int'(state), int'(ST_FAULT));
    clear_fault = 1;
    tick();
    clear_fault = 0;
    chk("flt_exit", int'(state), int'(ST_IDLE));
    chk("flt_exit_latched", int'(fault_latched), 0);

    // Random enable/fault/raw traffic against the model.
    enable = 1; rand_ctl = 1;
    repeat (40000) tick();
    rand_ctl = 0; fault_in = 0; clear_fault = 1; enable = 1;
    tick();
    clear_fault = 0;

    // Asynchronous reset mid-RUN with gates toggling.
    for (int i = 0; i < 8000; i++) begin tick(); if (state == ST_RUN) break; end
    chk("pre_reset_run", int'(state), int'(ST_RUN));
    raw_rand = 0;
    repeat (30) begin tick(); raw_a = ~raw_a; end
    repeat (60) tick();
    raw_rand = 1;
    repeat (5) tick();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_gates", int'({va, van, vb, vbn, vc, vcn}), 0);
    chk("arst_mod", int'(mod_index), 0);
    chk("arst_state", int'(state), int'(ST_IDLE));
    chk("arst_fault", int'(fault_latched), 0);
    enable = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
